// File: rtl/ps2_host_tx_if.sv
// CPU-side write port plus PS/2 pad signals of the host transmitter.
// master = CPU/pad side, slave = transmitter.
interface ps2_host_tx_if;
    logic       ps2clk_in;
    logic       ps2data_in;
    logic       ps2clk_oe;
    logic       ps2data_oe;
    logic [7:0] data;
    logic       dataload;
    logic       ps2busy;
    logic       ps2error;
    logic       done;

    modport master (
        output ps2clk_in, ps2data_in, data, dataload,
        input  ps2clk_oe, ps2data_oe, ps2busy, ps2error, done
    );

    modport slave (
        input  ps2clk_in, ps2data_in, data, dataload,
        output ps2clk_oe, ps2data_oe, ps2busy, ps2error, done
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, start, 8 data bits LSB first, odd parity,
// stop, device ACK; a timeout bounds the whole device-clocked part of the transfer.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2400,
    parameter int TIMEOUT_CYCLES = 360000,
    parameter int FILTER         = 8
) (
    input  logic               clk,
    input  logic               rst,
    ps2_host_tx_if.slave       bus
);
    localparam int FW = $clog2(FILTER + 1);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, START, SEND, ACK, WAIT_IDLE
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    sync_a, sync_b, filt;   // bit 0 = clock, bit 1 = data
    logic [FW-1:0] flt_cnt [2];
    logic          clk_fall;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;
    logic [3:0]    idx;
    logic [7:0]    data_q;
    logic          par_q;
    logic          data_low;
    logic          error_q;
    logic          done_q;
    logic          timeout;
    logic          bit_sel;
    logic          clk_oe, data_oe;

    // Synchronise both pads, then only accept a level held for FILTER samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a   <= 2'b11;
            sync_b   <= 2'b11;
            filt     <= 2'b11;
            clk_fall <= 1'b0;
            for (int i = 0; i < 2; i++) flt_cnt[i] <= '0;
        end else begin
            sync_a   <= {bus.ps2data_in, bus.ps2clk_in};
            sync_b   <= sync_a;
            clk_fall <= filt[0] & ~sync_b[0] & (flt_cnt[0] == FW'(FILTER - 1));
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == FW'(FILTER - 1)) begin
                    filt[i]    <= sync_b[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + FW'(1);
                end
            end
        end
    end

    assign timeout = (state == SEND || state == ACK || state == WAIT_IDLE) &&
                     (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    assign bit_sel = (idx < 4'd8) ? data_q[idx[2:0]] :
                     (idx == 4'd8) ? par_q : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (bus.dataload) state_nxt = INHIBIT;
            INHIBIT:   if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) state_nxt = START;
            START:     state_nxt = SEND;
            SEND: begin
                if (timeout)                          state_nxt = IDLE;
                else if (clk_fall && idx == 4'd9)     state_nxt = ACK;
            end
            ACK: begin
                if (timeout)       state_nxt = IDLE;
                else if (clk_fall) state_nxt = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (timeout || filt == 2'b11) state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        clk_oe  = (state == INHIBIT) || (state == START);
        data_oe = (state == START) || ((state == SEND) && data_low);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inh_cnt  <= '0;
            to_cnt   <= '0;
            idx      <= '0;
            data_q   <= '0;
            par_q    <= 1'b0;
            data_low <= 1'b0;
            error_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    data_low <= 1'b0;
                    if (bus.dataload) begin
                        data_q  <= bus.data;
                        par_q   <= ~^bus.data;
                        error_q <= 1'b0;
                        inh_cnt <= '0;
                    end
                end
                INHIBIT: inh_cnt <= inh_cnt + IW'(1);
                START: begin
                    to_cnt   <= '0;
                    idx      <= '0;
                    data_low <= 1'b1;   // keeps the start bit on the line until the first fall
                end
                SEND: begin
                    to_cnt <= to_cnt + TW'(1);
                    if (clk_fall) begin
                        data_low <= ~bit_sel;
                        idx      <= idx + 4'd1;
                    end
                end
                ACK: begin
                    to_cnt <= to_cnt + TW'(1);
                    if (clk_fall && filt[1]) error_q <= 1'b1;
                end
                WAIT_IDLE: begin
                    to_cnt <= to_cnt + TW'(1);
                    if (filt == 2'b11) done_q <= 1'b1;
                end
                default: ;
            endcase
            if (timeout) begin
                error_q  <= 1'b1;
                done_q   <= 1'b1;
                data_low <= 1'b0;
            end
        end
    end

    assign bus.ps2clk_oe  = clk_oe;
    assign bus.ps2data_oe = data_oe;
    assign bus.ps2busy    = (state != IDLE);
    assign bus.ps2error   = error_q;
    assign bus.done       = done_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench: a behavioural PS/2 device clocks each frame and captures bits on rising edges.
module tb_ps2_host_tx;
    localparam int INH  = 2400;
    localparam int TO   = 5000;
    localparam int FLT  = 8;
    localparam int HALF = 25;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_host_tx_if bus();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER(FLT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic dev_clk_low  = 1'b0;
    logic dev_data_low = 1'b0;
    assign bus.ps2clk_in  = ~(bus.ps2clk_oe  | dev_clk_low);
    assign bus.ps2data_in = ~(bus.ps2data_oe | dev_data_low);

    int checks = 0;
    int errors = 0;
    int inh_n = 0, st_n = 0, done_n = 0, done_busy = 0;

    always @(negedge clk) begin
        if (bus.ps2clk_oe && !bus.ps2data_oe) inh_n++;
        if (bus.ps2clk_oe && bus.ps2data_oe)  st_n++;
        if (bus.done) begin
            done_n++;
            if (bus.ps2busy) done_busy++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] b);
        bus.data     = b;
        bus.dataload = 1'b1;
        @(negedge clk);
        bus.dataload = 1'b0;
    endtask

    task automatic clear_mon();
        inh_n = 0; st_n = 0; done_n = 0; done_busy = 0;
    endtask

    // Waits for clock release with the start bit, then clocks falls; stops early
    // (clock held low) once fall number stop_at+1 has been given.
    task automatic device(input bit ack, input bit glitch, input int stop_at,
                          output logic [9:0] bits, output bit ok);
        int t;
        bits = '0;
        ok   = 1'b0;
        t    = 0;
        while (!(bus.ps2clk_oe == 1'b0 && bus.ps2data_oe == 1'b1) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 4000) return;
        cyc(HALF);
        for (int i = 0; i < 11; i++) begin
            if (glitch && i == 4) begin
                dev_clk_low = 1'b1;
                cyc(3);
                dev_clk_low = 1'b0;
                cyc(HALF);
            end
            dev_clk_low = 1'b1;
            cyc(HALF);
            if (i == stop_at) begin
                ok = 1'b1;
                return;
            end
            dev_clk_low = 1'b0;
            if (i < 10) bits[i] = bus.ps2data_in;
            if (i == 9 && ack) dev_data_low = 1'b1;
            cyc(HALF);
        end
        cyc(HALF);
        dev_data_low = 1'b0;
        ok = 1'b1;
    endtask

    task automatic run_tx(input string tag, input logic [7:0] b, input bit ack, input bit glitch,
                          input bit extra_load, input logic [9:0] exp_bits, input bit exp_err);
        logic [9:0] bits;
        bit ok;
        int t;
        clear_mon();
        load(b);
        if (extra_load) begin
            cyc(100);
            load(8'h55);
        end
        device(ack, glitch, 99, bits, ok);
        check($sformatf("%s_release", tag), 32'(ok), 32'd1);
        t = 0;
        while (done_n == 0 && t < 3000) begin
            cyc(1);
            t++;
        end
        cyc(2);
        check($sformatf("%s_bits", tag), 32'(bits), 32'(exp_bits));
        check($sformatf("%s_inhibit", tag), 32'(inh_n), INH);
        check($sformatf("%s_start", tag), 32'(st_n), 32'd1);
        check($sformatf("%s_done_cnt", tag), 32'(done_n), 32'd1);
        check($sformatf("%s_busy_at_done", tag), 32'(done_busy), 32'd0);
        check($sformatf("%s_error", tag), 32'(bus.ps2error), 32'(exp_err));
        check($sformatf("%s_busy", tag), 32'(bus.ps2busy), 32'd0);
        check($sformatf("%s_oe", tag), 32'({bus.ps2clk_oe, bus.ps2data_oe}), 32'd0);
    endtask

    initial begin
        logic [9:0] bits;
        bit ok;
        int t;

        // Reset with a simultaneous write strobe
        bus.data     = 8'hED;
        bus.dataload = 1'b1;
        rst          = 1'b1;
        cyc(2);
        check("rst_clk_oe", 32'(bus.ps2clk_oe), 32'd0);
        check("rst_data_oe", 32'(bus.ps2data_oe), 32'd0);
        check("rst_busy", 32'(bus.ps2busy), 32'd0);
        check("rst_error", 32'(bus.ps2error), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        rst          = 1'b0;
        bus.dataload = 1'b0;
        cyc(3);
        check("rst_load_busy", 32'(bus.ps2busy), 32'd0);
        check("rst_load_clk_oe", 32'(bus.ps2clk_oe), 32'd0);

        // tag, byte, ack, glitch, load-while-busy, {stop, parity, data}, error
        run_tx("ed",     8'hED, 1'b1, 1'b0, 1'b0, 10'h3ED, 1'b0);
        run_tx("f4",     8'hF4, 1'b1, 1'b0, 1'b0, 10'h2F4, 1'b0);
        run_tx("ff",     8'hFF, 1'b1, 1'b0, 1'b0, 10'h3FF, 1'b0);
        run_tx("nack",   8'h5A, 1'b0, 1'b0, 1'b0, 10'h35A, 1'b1);
        run_tx("glitch", 8'h3C, 1'b1, 1'b1, 1'b0, 10'h33C, 1'b0);
        run_tx("busyld", 8'hA5, 1'b1, 1'b0, 1'b1, 10'h3A5, 1'b0);

        // Timeout: device never clocks
        clear_mon();
        load(8'h12);
        t = 0;
        while (!(bus.ps2clk_oe == 1'b0 && bus.ps2data_oe == 1'b1) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("to_release_seen", 32'(t < 4000), 32'd1);
        cyc(TO - 1);
        check("to_pre_busy", 32'(bus.ps2busy), 32'd1);
        check("to_pre_done", 32'(bus.done), 32'd0);
        check("to_pre_data_oe", 32'(bus.ps2data_oe), 32'd1);
        cyc(1);
        check("to_done", 32'(bus.done), 32'd1);
        check("to_busy", 32'(bus.ps2busy), 32'd0);
        check("to_error", 32'(bus.ps2error), 32'd1);
        check("to_oe", 32'({bus.ps2clk_oe, bus.ps2data_oe}), 32'd0);
        cyc(2);
        check("to_done_cnt", 32'(done_n), 32'd1);

        // Reset in the middle of the frame, after the 4th fall (0x00: bit 3 drives low)
        clear_mon();
        load(8'h00);
        device(1'b1, 1'b0, 3, bits, ok);
        check("midrst_reached", 32'(ok), 32'd1);
        check("midrst_pre_data_oe", 32'(bus.ps2data_oe), 32'd1);
        check("midrst_pre_busy", 32'(bus.ps2busy), 32'd1);
        rst = 1'b1;
        cyc(1);
        check("midrst_oe", 32'({bus.ps2clk_oe, bus.ps2data_oe}), 32'd0);
        check("midrst_busy", 32'(bus.ps2busy), 32'd0);
        rst         = 1'b0;
        dev_clk_low = 1'b0;
        cyc(40);
        check("midrst_no_done", 32'(done_n), 32'd0);
        check("midrst_error", 32'(bus.ps2error), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
